// File: rtl/hack_pc_jump_unit_if.sv
// Bundle of control, datapath and status signals between the Hack core and its PC/jump stage.
// The branch_count signal only exists when PC_BRANCH_COUNT_EN is defined.
interface hack_pc_jump_unit_if #(
    parameter int WIDTH = 16
);
    logic             clr;
    logic             stall;
    logic             alu_valid;
    logic [WIDTH-1:0] alu_out;
    logic [2:0]       jmp;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] pc;
    logic             zr;
    logic             ng;
    logic             jump_taken;
    logic             halted;
`ifdef PC_BRANCH_COUNT_EN
    logic [WIDTH-1:0] branch_count;

    modport master (
        output clr, stall, alu_valid, alu_out, jmp, a_reg,
        input  pc, zr, ng, jump_taken, halted, branch_count
    );
    modport slave (
        input  clr, stall, alu_valid, alu_out, jmp, a_reg,
        output pc, zr, ng, jump_taken, halted, branch_count
    );
`else
    modport master (
        output clr, stall, alu_valid, alu_out, jmp, a_reg,
        input  pc, zr, ng, jump_taken, halted
    );
    modport slave (
        input  clr, stall, alu_valid, alu_out, jmp, a_reg,
        output pc, zr, ng, jump_taken, halted
    );
`endif
endinterface

// File: rtl/hack_pc_jump_unit.sv
// Hack CPU program counter and jump resolution, with self-jump halt detection.
// Optional taken-jump counter enabled by defining PC_BRANCH_COUNT_EN.
module hack_pc_jump_unit #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hack_pc_jump_unit_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pc_q;
    logic             zr_q;
    logic             ng_q;
    logic             jump_taken_q;

    // Zero detect is built from one 8-way OR per byte lane.
    logic [1:0] byte_or;
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_or8way
            assign byte_or[gi] = |bus.alu_out[gi*8 +: 8];
        end
    endgenerate

    logic zr_c;
    logic ng_c;
    logic take;
    logic self_jump;

    assign zr_c      = ~(byte_or[1] | byte_or[0]);
    assign ng_c      = bus.alu_out[WIDTH-1];
    assign take      = bus.alu_valid & ((bus.jmp[2] & ng_c) | (bus.jmp[1] & zr_c) |
                                        (bus.jmp[0] & ~ng_c & ~zr_c));
    assign self_jump = take & (bus.jmp == 3'b111) & (bus.a_reg == pc_q);

`ifdef PC_BRANCH_COUNT_EN
    logic [WIDTH-1:0] branch_count_q;
    assign bus.branch_count = branch_count_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= '0;
            zr_q         <= 1'b0;
            ng_q         <= 1'b0;
            jump_taken_q <= 1'b0;
`ifdef PC_BRANCH_COUNT_EN
            branch_count_q <= '0;
`endif
        end else begin
            jump_taken_q <= 1'b0;
            if (bus.clr) begin
                state_q <= RUN;
                pc_q    <= '0;
                zr_q    <= 1'b0;
                ng_q    <= 1'b0;
`ifdef PC_BRANCH_COUNT_EN
                branch_count_q <= '0;
`endif
            end else if (state_q == RUN && !bus.stall) begin
                if (bus.alu_valid) begin
                    zr_q <= zr_c;
                    ng_q <= ng_c;
                end
                if (take) begin
                    jump_taken_q <= 1'b1;
`ifdef PC_BRANCH_COUNT_EN
                    if (branch_count_q != '1)
                        branch_count_q <= branch_count_q + 1'b1;
`endif
                    // A jump to itself is the halt idiom: park here rather than reload.
                    if (self_jump)
                        state_q <= HALT;
                    else
                        pc_q <= bus.a_reg;
                end else begin
                    pc_q <= pc_q + 1'b1;
                end
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.zr         = zr_q;
    assign bus.ng         = ng_q;
    assign bus.jump_taken = jump_taken_q;
    assign bus.halted     = (state_q == HALT);
endmodule

// File: tb/tb_hack_pc_jump_unit.sv
// Directed-vector bench for hack_pc_jump_unit; expected values are hand-computed.
module tb_hack_pc_jump_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hack_pc_jump_unit_if #(.WIDTH(16)) bus ();
    hack_pc_jump_unit #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] alu, input logic [2:0] j,
                         input logic [15:0] a);
        bus.alu_valid = v;
        bus.alu_out   = alu;
        bus.jmp       = j;
        bus.a_reg     = a;
    endtask

    task automatic chk_bc(input string tag, input logic [15:0] exp);
`ifdef PC_BRANCH_COUNT_EN
        chk(tag, {16'd0, bus.branch_count}, {16'd0, exp});
`else
        if (exp == 16'hFFFF) $display("branch counter absent: %s", tag);
`endif
    endtask

    initial begin
        bus.clr   = 1'b0;
        bus.stall = 1'b0;
        drive(1'b0, 16'h0, 3'b000, 16'h0);
        #12;
        chk("rst_pc", {16'd0, bus.pc}, 32'h0);
        chk("rst_zr", {31'd0, bus.zr}, 32'h0);
        chk("rst_ng", {31'd0, bus.ng}, 32'h0);
        chk("rst_jt", {31'd0, bus.jump_taken}, 32'h0);
        chk("rst_halted", {31'd0, bus.halted}, 32'h0);
        chk_bc("rst_bc", 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("free_pc%0d", i), {16'd0, bus.pc}, i);
            chk($sformatf("free_jt%0d", i), {31'd0, bus.jump_taken}, 32'h0);
        end
        tick();
        tick();
        chk("pc_at5", {16'd0, bus.pc}, 32'h5);

        // JEQ on zero result
        drive(1'b1, 16'h0000, 3'b010, 16'h0040);
        tick();
        chk("jeq_pc", {16'd0, bus.pc}, 32'h40);
        chk("jeq_zr", {31'd0, bus.zr}, 32'h1);
        chk("jeq_ng", {31'd0, bus.ng}, 32'h0);
        chk("jeq_jt", {31'd0, bus.jump_taken}, 32'h1);
        // JEQ on negative result: falls through
        drive(1'b1, 16'h8001, 3'b010, 16'h0040);
        tick();
        chk("jeq_nt_pc", {16'd0, bus.pc}, 32'h41);
        chk("jeq_nt_ng", {31'd0, bus.ng}, 32'h1);
        chk("jeq_nt_zr", {31'd0, bus.zr}, 32'h0);
        chk("jeq_nt_jt", {31'd0, bus.jump_taken}, 32'h0);
        // High byte only nonzero: JGT taken, JLT not
        drive(1'b1, 16'h0100, 3'b001, 16'h0080);
        tick();
        chk("jgt_hi_pc", {16'd0, bus.pc}, 32'h80);
        chk("jgt_hi_zr", {31'd0, bus.zr}, 32'h0);
        chk("jgt_hi_jt", {31'd0, bus.jump_taken}, 32'h1);
        drive(1'b1, 16'h0100, 3'b100, 16'h0200);
        tick();
        chk("jlt_hi_pc", {16'd0, bus.pc}, 32'h81);
        // Low byte only nonzero: JEQ not taken
        drive(1'b1, 16'h0001, 3'b010, 16'h0200);
        tick();
        chk("jeq_lo_pc", {16'd0, bus.pc}, 32'h82);
        // jmp=000 never jumps even on zero
        drive(1'b1, 16'h0000, 3'b000, 16'h0200);
        tick();
        chk("nojmp_pc", {16'd0, bus.pc}, 32'h83);
        chk("nojmp_zr", {31'd0, bus.zr}, 32'h1);
        // alu_valid=0 blocks the jump
        drive(1'b0, 16'h0000, 3'b111, 16'h0200);
        tick();
        chk("inval_pc", {16'd0, bus.pc}, 32'h84);
        // Unconditional
        drive(1'b1, 16'h8000, 3'b111, 16'h0300);
        tick();
        chk("jmp_pc", {16'd0, bus.pc}, 32'h300);
        chk_bc("bc_3", 16'd3);

        // Stall beats a taking jump
        bus.stall = 1'b1;
        drive(1'b1, 16'h0000, 3'b010, 16'h0400);
        tick();
        chk("stall_pc", {16'd0, bus.pc}, 32'h300);
        chk("stall_zr", {31'd0, bus.zr}, 32'h0);
        chk("stall_ng", {31'd0, bus.ng}, 32'h1);
        chk("stall_jt", {31'd0, bus.jump_taken}, 32'h0);
        chk_bc("stall_bc", 16'd3);
        bus.stall = 1'b0;
        tick();
        chk("unstall_pc", {16'd0, bus.pc}, 32'h400);
        chk("unstall_zr", {31'd0, bus.zr}, 32'h1);
        chk("unstall_jt", {31'd0, bus.jump_taken}, 32'h1);
        chk_bc("unstall_bc", 16'd4);

        // clr beats stall
        bus.clr   = 1'b1;
        bus.stall = 1'b1;
        tick();
        bus.clr   = 1'b0;
        bus.stall = 1'b0;
        chk("clr_pc", {16'd0, bus.pc}, 32'h0);
        chk("clr_zr", {31'd0, bus.zr}, 32'h0);
        chk("clr_jt", {31'd0, bus.jump_taken}, 32'h0);
        chk_bc("clr_bc", 16'd0);

        // Halt idiom
        drive(1'b1, 16'hFFFF, 3'b111, 16'h0010);
        tick();
        chk("pre_halt_pc", {16'd0, bus.pc}, 32'h10);
        chk("pre_halt_h", {31'd0, bus.halted}, 32'h0);
        tick();
        chk("halt_pc", {16'd0, bus.pc}, 32'h10);
        chk("halt_h", {31'd0, bus.halted}, 32'h1);
        chk("halt_jt", {31'd0, bus.jump_taken}, 32'h1);
        chk_bc("halt_bc", 16'd2);
        for (int i = 0; i < 10; i++) begin
            bus.stall = i[0];
            drive(1'b1, 16'h0000 + 16'(i), 3'(i), 16'h0100 + 16'(i));
            tick();
            chk($sformatf("halt_hold_pc%0d", i), {16'd0, bus.pc}, 32'h10);
            chk($sformatf("halt_hold_h%0d", i), {31'd0, bus.halted}, 32'h1);
            chk($sformatf("halt_hold_jt%0d", i), {31'd0, bus.jump_taken}, 32'h0);
        end
        bus.stall = 1'b0;
        chk("halt_ng", {31'd0, bus.ng}, 32'h1);
        chk_bc("halt_hold_bc", 16'd2);
        drive(1'b0, 16'h0, 3'b000, 16'h0);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("unhalt_pc", {16'd0, bus.pc}, 32'h0);
        chk("unhalt_h", {31'd0, bus.halted}, 32'h0);
        chk_bc("unhalt_bc", 16'd0);

        // PC wrap
        drive(1'b1, 16'h0000, 3'b111, 16'hFFFF);
        tick();
        chk("to_ffff_pc", {16'd0, bus.pc}, 32'hFFFF);
        drive(1'b0, 16'h0, 3'b000, 16'h0);
        tick();
        chk("wrap_pc", {16'd0, bus.pc}, 32'h0);
        chk_bc("wrap_bc", 16'd1);

`ifdef PC_BRANCH_COUNT_EN
        // Drive the counter to saturation with alternating targets
        for (int i = 0; i < 65534; i++) begin
            drive(1'b1, 16'h0000, 3'b111, (i % 2 == 0) ? 16'h0001 : 16'h0002);
            tick();
        end
        chk_bc("sat_bc", 16'hFFFF);
        drive(1'b1, 16'h0000, 3'b111, 16'h0005);
        tick();
        chk("sat_pc", {16'd0, bus.pc}, 32'h5);
        chk_bc("sat_hold_bc", 16'hFFFF);
`endif

        // Asynchronous reset mid-cycle
        drive(1'b1, 16'h0000, 3'b111, 16'h0077);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", {16'd0, bus.pc}, 32'h0);
        chk("arst_jt", {31'd0, bus.jump_taken}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hack_pc_jump_unit.md
# hack_pc_jump_unit

Program-counter and jump-resolution stage of the Hack CPU, directly downstream of the OR-reduction gates. It reduces the 16-bit ALU result to zero and negative flags using two 8-way OR reductions. It evaluates the C-instruction jump bits against those flags and advances or loads the program counter. It also detects the canonical self-jump halt idiom and freezes the core until restart.

## Interface
Parameters:
- `WIDTH`, 16, datapath and PC width (only 16 is supported).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `clr`  in  1  synchronous restart (the Hack reset button); PC to 0, leave HALT.
- `stall`  in  1  freeze all state for this cycle.
- `alu_valid`  in  1  current instruction is a C-instruction with a valid `alu_out`.
- `alu_out`  in  16  ALU result of the current instruction.
- `jmp`  in  3  jump bits j1 j2 j3 (lt, eq, gt).
- `a_reg`  in  16  jump target, the A register.
- `pc`  out  16  address of the instruction to fetch.
- `zr`  out  1  registered zero flag of the last accepted ALU result.
- `ng`  out  1  registered negative flag of the last accepted ALU result.
- `jump_taken`  out  1  one-cycle pulse; the previous edge loaded `pc` from `a_reg`.
- `halted`  out  1  high while in HALT.
- `branch_count`  out  16  taken-jump counter; present only with `PC_BRANCH_COUNT_EN`.

## Operation
- Combinational flags:
  - `zr_c = ~(|alu_out[15:8] | |alu_out[7:0])`, computed with two or8way reductions.
  - `ng_c = alu_out[15]`.
- `take = alu_valid & ((jmp[2]&ng_c) | (jmp[1]&zr_c) | (jmp[0]&~ng_c&~zr_c))`.
- `jmp=3'b111` is an unconditional jump. `jmp=3'b000` never jumps.
- States are RUN and HALT. `rst_n` low forces RUN.
- RUN edge priority, highest first:
  1. `clr`: `pc`=0, flags=0, stay in RUN.
  2. `stall`: hold everything.
  3. `take & jmp==3'b111 & a_reg==pc`: go to HALT, `pc` unchanged.
  4. `take`: `pc`=`a_reg`.
  5. Otherwise: `pc`=`pc`+1, wrapping from 0xFFFF to 0x0000.
- Flag registers load `zr_c` and `ng_c` on any RUN, non-stall edge where `alu_valid`=1. Otherwise they hold.
- HALT:
  - `pc`, the flags and the counter hold.
  - `stall`, `alu_valid` and `jmp` are ignored.
  - `clr` returns to RUN with `pc`=0.
- The halting self-jump counts as a taken jump for `jump_taken` and `branch_count`.
- Reset values: `pc`=0, `zr`=0, `ng`=0, `jump_taken`=0, `halted`=0, `branch_count`=0.

## Timing
- Latency is one edge. Inputs sampled at edge N determine `pc`, the flags and `halted` after edge N.
- `jump_taken` is registered. It is high for exactly the cycle following an edge that applied priority 3 or 4, and is 0 after `clr`, stall and increment edges.
- `stall` and `take` in the same cycle: the stall wins, and the jump is lost unless its inputs are re-presented.
- `clr` and `stall` together: `clr` wins.
- `rst_n` assertion mid-cycle clears all state immediately without waiting for `clk`. Deassertion is synchronised externally.
- `halted` rises in the cycle after the halting edge. It falls the cycle after the `clr` edge.

## Configuration
- `PC_BRANCH_COUNT_EN` defined:
  - `branch_count` port exists.
  - It increments on every edge where `jump_taken` will be set, saturating at 0xFFFF.
  - It is cleared by `rst_n` and by `clr`.
- `PC_BRANCH_COUNT_EN` undefined: the port and the counter logic are absent, and all other behaviour is identical.

## Test plan
- Reset then 3 free edges with `alu_valid`=0: `pc` goes 0, 1, 2, 3; `zr`=`ng`=0; `jump_taken` stays 0.
- `pc`=5, `alu_out`=0x0000, `jmp`=010, `a_reg`=0x0040: `pc`=0x0040, `zr`=1, `ng`=0, `jump_taken` pulses 1 cycle. Repeat with `alu_out`=0x8001 and `jmp`=010: no jump, `pc`=0x0041, `ng`=1.
- Per-condition check: `alu_out`=0x0100 (nonzero high byte only) with `jmp`=001 jumps. `jmp`=100 does not jump. Confirms the high-byte OR path.
- `stall`=1 with a valid taking jump: `pc`, flags and `branch_count` hold, `jump_taken`=0. Release `stall` with the same inputs and the jump occurs.
- Halt sequence:
  - `pc`=0x0010, `a_reg`=0x0010, `jmp`=111, `alu_valid`=1: `halted`=1 and `pc` stays 0x0010 for 10 cycles despite toggling inputs.
  - `clr`: `pc`=0 and `halted`=0.
- With `PC_BRANCH_COUNT_EN`: three taken jumps give `branch_count`=3. Preload to 0xFFFF via 0xFFFF jumps (or a forced value); a further jump leaves 0xFFFF. `pc`=0xFFFF incrementing wraps to 0x0000.
